// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared definitions for the RAM port arbiter and its round-robin helper:
//   the transaction FSM state encoding and the requester identifiers used
//   for grant_id, last_grant and the arbiter's grant output.
package ram_port_arbiter_pkg;

  // Transaction sequencer states: idle, drive the RAM for one cycle,
  // wait out the read latency, then pulse the winner's ack.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } arb_state_t;

  // Requester identifiers, also the bit positions in the packed request vector.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_arb_rr2.sv
// arb_rr2
//   Purely combinational two-way arbiter between the CPU and DMA requesters.
//   Ports:
//     req        in  2  request vector, bit 0 = CPU, bit 1 = DMA
//     last_grant in  1  owner of the previous grant (REQ_CPU / REQ_DMA)
//     prio_mode  in  1  0 = round-robin on contention, 1 = CPU always wins
//     gnt_id     out 1  chosen requester; only meaningful when req != 0
module arb_rr2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       prio_mode,
  output logic       gnt_id
);

  // A lone requester always wins. On contention, fixed mode favours the CPU
  // and round-robin mode hands the grant to whoever did not have it last.
  always_comb begin
    gnt_id = REQ_CPU;
    if (req == 2'b10) begin
      gnt_id = REQ_DMA;
    end else if (req == 2'b11) begin
      gnt_id = prio_mode ? REQ_CPU : !last_grant;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM between the CPU memory path and a DMA/loader
//   port. Each access runs as a single in-flight transaction:
//   IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> ACK -> IDLE.
//   Ports:
//     clk, rst                      clock (rising edge), synchronous active-high reset
//     cpu_req/we/addr/wdata         CPU request; req held until cpu_ack
//     cpu_ack, cpu_rdata            one-cycle completion pulse, read data (held)
//     dma_req/we/addr/wdata         DMA request, same protocol as the CPU
//     dma_ack, dma_rdata            one-cycle completion pulse, read data (held)
//     ram_address, ram_data         RAM address/write data, hold outside ISSUE
//     ram_rden, ram_wren            RAM strobes, only ever high in ISSUE
//     ram_q                         RAM read data, valid RD_LAT cycles after sampling
//     busy                          high whenever the FSM is not idle
//     grant_id                      owner of the current/last transaction (0 CPU, 1 DMA)
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              grant_id
);

  localparam int              CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic             last_grant;
  logic             lat_we;
  logic [CNT_W-1:0] wait_cnt;
  logic             gnt_id;
  logic             start_txn;

  assign start_txn = (state == S_IDLE) && (cpu_req || dma_req);

  arb_rr2 u_arb (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant),
    .prio_mode  (PRIO_MODE != 0),
    .gnt_id     (gnt_id)
  );

  // State register. Reset drops any in-flight transaction on the floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe/ack decode. Strobes only exist in ISSUE, so the
  // RAM never sees read and write together and never sees a stale strobe.
  always_comb begin
    state_next = state;
    ram_wren   = 1'b0;
    ram_rden   = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (cpu_req || dma_req) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        ram_wren   = lat_we;
        ram_rden   = !lat_we;
        state_next = lat_we ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == CNT_LAST) state_next = S_ACK;
      end
      S_ACK: begin
        cpu_ack    = (grant_id == REQ_CPU);
        dma_ack    = (grant_id == REQ_DMA);
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Grant bookkeeping and request latch. The winner's command is captured
  // straight into the RAM-facing registers on the IDLE->ISSUE edge, so the
  // requester's inputs are free to change for the rest of the transaction
  // and the RAM address/data naturally hold their last values afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= REQ_DMA;
      grant_id    <= REQ_CPU;
      lat_we      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else if (start_txn) begin
      last_grant <= gnt_id;
      grant_id   <= gnt_id;
      if (gnt_id == REQ_DMA) begin
        lat_we      <= dma_we;
        ram_address <= dma_addr;
        ram_data    <= dma_wdata;
      end else begin
        lat_we      <= cpu_we;
        ram_address <= cpu_addr;
        ram_data    <= cpu_wdata;
      end
    end
  end

  // Read latency counter and read-data capture. The counter is cleared while
  // the address is being issued and counts WAIT cycles; ram_q is taken in the
  // last WAIT cycle and steered to the owner's rdata register, which then
  // holds until the owner's next read or a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      if (wait_cnt == CNT_LAST) begin
        if (grant_id == REQ_DMA) begin
          dma_rdata <= ram_q;
        end else begin
          cpu_rdata <= ram_q;
        end
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Exercises two arbiter instances side by side:
//     instance 0: RD_LAT=1, round-robin arbitration
//     instance 1: RD_LAT=2, CPU fixed priority
//   Each instance talks to its own behavioural RAM. Expected results come from
//   a reference memory, the latency rule (write n+2, read n+2+RD_LAT) and the
//   grant rule applied transaction by transaction.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int NDUT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst       [NDUT];
  logic              cpu_req   [NDUT];
  logic              cpu_we    [NDUT];
  logic [ADDR_W-1:0] cpu_addr  [NDUT];
  logic [DATA_W-1:0] cpu_wdata [NDUT];
  logic              dma_req   [NDUT];
  logic              dma_we    [NDUT];
  logic [ADDR_W-1:0] dma_addr  [NDUT];
  logic [DATA_W-1:0] dma_wdata [NDUT];

  wire               cpu_ack     [NDUT];
  wire  [DATA_W-1:0] cpu_rdata   [NDUT];
  wire               dma_ack     [NDUT];
  wire  [DATA_W-1:0] dma_rdata   [NDUT];
  wire  [ADDR_W-1:0] ram_address [NDUT];
  wire  [DATA_W-1:0] ram_data    [NDUT];
  wire               ram_rden    [NDUT];
  wire               ram_wren    [NDUT];
  wire               busy        [NDUT];
  wire               grant_id    [NDUT];

  // Reference model state
  logic [DATA_W-1:0] ref_mem   [NDUT][512];
  bit                ref_valid [NDUT][512];
  logic [ADDR_W-1:0] wr_list   [NDUT][512];
  int                wr_cnt    [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int model_lat(input int d);
    return d + 1;
  endfunction

  function automatic bit model_prio(input int d);
    return (d == 1);
  endfunction

  // One DUT plus a behavioural RAM per instance; the RAM read path is a
  // short pipeline so q is valid RD_LAT cycles after the sampling edge.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [DATA_W-1:0] mem    [512];
    logic [DATA_W-1:0] q_pipe [2];
    wire  [DATA_W-1:0] q_bus;
    assign q_bus = q_pipe[g];

    always @(posedge clk) begin
      if (ram_wren[g]) mem[ram_address[g]] <= ram_data[g];
      if (ram_rden[g]) q_pipe[0] <= mem[ram_address[g]];
      q_pipe[1] <= q_pipe[0];
    end

    ram_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RD_LAT    (g + 1),
      .PRIO_MODE (g)
    ) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .cpu_req     (cpu_req[g]),
      .cpu_we      (cpu_we[g]),
      .cpu_addr    (cpu_addr[g]),
      .cpu_wdata   (cpu_wdata[g]),
      .cpu_ack     (cpu_ack[g]),
      .cpu_rdata   (cpu_rdata[g]),
      .dma_req     (dma_req[g]),
      .dma_we      (dma_we[g]),
      .dma_addr    (dma_addr[g]),
      .dma_wdata   (dma_wdata[g]),
      .dma_ack     (dma_ack[g]),
      .dma_rdata   (dma_rdata[g]),
      .ram_address (ram_address[g]),
      .ram_data    (ram_data[g]),
      .ram_rden    (ram_rden[g]),
      .ram_wren    (ram_wren[g]),
      .ram_q       (q_bus),
      .busy        (busy[g]),
      .grant_id    (grant_id[g])
    );
  end

  task automatic drive(input int d, input bit who, input bit req, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (who == 1'b0) begin
      cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
    end else begin
      dma_req[d] = req; dma_we[d] = we; dma_addr[d] = addr; dma_wdata[d] = wdata;
    end
  endtask

  task automatic note_write(input int d, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    ref_mem[d][addr] = data;
    if (!ref_valid[d][addr]) begin
      ref_valid[d][addr] = 1'b1;
      wr_list[d][wr_cnt[d]] = addr;
      wr_cnt[d]++;
    end
  endtask

  task automatic reset_dut(input int d);
    rst[d] = 1'b1;
    repeat (2) @(negedge clk);
    rst[d] = 1'b0;
  endtask

  // Single transaction from a lone requester, starting at a negedge in IDLE.
  // k counts cycles after the request cycle n. Returns at a negedge in IDLE.
  task automatic run_txn(input int d, input bit who, input bit we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input string tag);
    int exp_lat;
    bit got;
    logic [5:0] exp_v, act_v;
    logic [DATA_W-1:0] rd, want_rd;
    exp_lat = we ? 2 : 2 + model_lat(d);
    want_rd = ref_mem[d][addr];
    got = 1'b0;
    drive(d, who, 1'b1, we, addr, wdata);
    for (int k = 1; k <= exp_lat + 3 && !got; k++) begin
      @(negedge clk);
      exp_v = {(k == 1) && we, (k == 1) && !we, k <= exp_lat, who,
               (k == exp_lat) && !who, (k == exp_lat) && who};
      act_v = {ram_wren[d], ram_rden[d], busy[d], grant_id[d], cpu_ack[d], dma_ack[d]};
      n_checks++;
      if (act_v !== exp_v)
        $display("[TB] FAIL %s_ctl dut%0d k=%0d: got %b expected %b (wren rden busy gid cack dack)",
                 tag, d, k, act_v, exp_v);
      else n_pass++;
      if (k == 1) begin
        n_checks++;
        if (ram_address[d] !== addr || (we && ram_data[d] !== wdata))
          $display("[TB] FAIL %s_bus dut%0d: got addr %0h data %0h expected addr %0h data %0h",
                   tag, d, ram_address[d], ram_data[d], addr, wdata);
        else n_pass++;
      end
      if ((who ? dma_ack[d] : cpu_ack[d]) === 1'b1) begin
        got = 1'b1;
        drive(d, who, 1'b0, we, addr, wdata);
        if (!we) begin
          rd = who ? dma_rdata[d] : cpu_rdata[d];
          n_checks++;
          if (rd !== want_rd)
            $display("[TB] FAIL %s_rdata dut%0d addr %0h: got %0h expected %0h", tag, d, addr, rd, want_rd);
          else n_pass++;
        end
      end
    end
    if (!got) begin
      n_checks++;
      $display("[TB] FAIL %s_timeout dut%0d: got no ack expected ack at k=%0d", tag, d, exp_lat);
      drive(d, who, 1'b0, we, addr, wdata);
    end
    @(negedge clk);
    rd = who ? dma_rdata[d] : cpu_rdata[d];
    n_checks++;
    if (busy[d] !== 1'b0 || (!we && rd !== want_rd))
      $display("[TB] FAIL %s_after dut%0d: got busy %b rdata %0h expected busy 0 rdata %0h",
               tag, d, busy[d], rd, want_rd);
    else n_pass++;
    if (we) note_write(d, addr, wdata);
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if ({ram_rden[d], ram_wren[d], busy[d], grant_id[d], cpu_ack[d], dma_ack[d]} !== 6'b0)
        $display("[TB] FAIL reset_ctl dut%0d: got %b expected 000000", d,
                 {ram_rden[d], ram_wren[d], busy[d], grant_id[d], cpu_ack[d], dma_ack[d]});
      else n_pass++;
      n_checks++;
      if (ram_address[d] !== '0 || ram_data[d] !== '0 || cpu_rdata[d] !== '0 || dma_rdata[d] !== '0)
        $display("[TB] FAIL reset_data dut%0d: got addr %0h data %0h crd %0h drd %0h expected all 0",
                 d, ram_address[d], ram_data[d], cpu_rdata[d], dma_rdata[d]);
      else n_pass++;
      rst[d] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_write_read(input int d);
    run_txn(d, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, "cpu_wr");
    run_txn(d, 1'b0, 1'b0, 9'h010, 32'h0, "cpu_rd");
    run_txn(d, 1'b1, 1'b1, 9'h1FF, 32'hC0FFEE00 + d, "dma_wr_top");
    run_txn(d, 1'b1, 1'b0, 9'h1FF, 32'h0, "dma_rd_top");
  endtask

  // Both requesters hold req high; the grant sequence is predicted from the
  // arbitration rule. After six grants the CPU backs off and DMA must win alone.
  task automatic test_contention(input int d);
    bit last, want;
    int acks, budget;
    logic [ADDR_W-1:0] a_cpu, a_dma;
    logic [DATA_W-1:0] w_cpu, w_dma;
    a_cpu = ADDR_W'(9'h020 + d);
    a_dma = ADDR_W'(9'h040 + d);
    w_cpu = $urandom;
    w_dma = $urandom;
    reset_dut(d);
    last = 1'b1;
    drive(d, 1'b0, 1'b1, 1'b1, a_cpu, w_cpu);
    drive(d, 1'b1, 1'b1, 1'b1, a_dma, w_dma);
    acks = 0;
    budget = 0;
    while (acks < 7 && budget < 80) begin
      @(negedge clk);
      budget++;
      if (cpu_ack[d] === 1'b1 || dma_ack[d] === 1'b1) begin
        if (acks < 6) begin
          want = model_prio(d) ? 1'b0 : !last;
          last = want;
        end else begin
          want = 1'b1;
        end
        n_checks++;
        if ({cpu_ack[d], dma_ack[d], grant_id[d]} !== {!want, want, want})
          $display("[TB] FAIL contend_grant dut%0d #%0d: got cack %b dack %b gid %b expected owner %0d",
                   d, acks, cpu_ack[d], dma_ack[d], grant_id[d], want);
        else n_pass++;
        if (acks == 5) cpu_req[d] = 1'b0;
        if (acks == 6) dma_req[d] = 1'b0;
        acks++;
      end
    end
    if (acks < 7) begin
      n_checks++;
      $display("[TB] FAIL contend_timeout dut%0d: got %0d acks expected 7", d, acks);
      cpu_req[d] = 1'b0;
      dma_req[d] = 1'b0;
    end
    @(negedge clk);
    note_write(d, a_cpu, w_cpu);
    note_write(d, a_dma, w_dma);
    run_txn(d, 1'b1, 1'b0, a_cpu, 32'h0, "contend_rd_cpu_word");
    run_txn(d, 1'b0, 1'b0, a_dma, 32'h0, "contend_rd_dma_word");
  endtask

  task automatic test_reset_mid_read(input int d);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(9'h0C0 + d);
    run_txn(d, 1'b1, 1'b1, a, 32'hA5A50001 + d, "pre_wr");
    run_txn(d, 1'b1, 1'b0, a, 32'h0, "pre_rd");
    drive(d, 1'b1, 1'b1, 1'b0, a, 32'h0);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy[d], ram_rden[d], ram_wren[d], dma_ack[d]} !== 4'b1000)
      $display("[TB] FAIL rstwait_state dut%0d: got %b expected 1000 (busy rden wren dack)",
               d, {busy[d], ram_rden[d], ram_wren[d], dma_ack[d]});
    else n_pass++;
    rst[d] = 1'b1;
    dma_req[d] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy[d], ram_rden[d], ram_wren[d], dma_ack[d], grant_id[d]} !== 5'b0 || dma_rdata[d] !== '0)
      $display("[TB] FAIL rstwait_cleared dut%0d: got ctl %b dma_rdata %0h expected 00000 and 0",
               d, {busy[d], ram_rden[d], ram_wren[d], dma_ack[d], grant_id[d]}, dma_rdata[d]);
    else n_pass++;
    rst[d] = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (dma_ack[d] !== 1'b0 || busy[d] !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) $display("[TB] FAIL rstwait_noack dut%0d: got ack/busy activity expected none", d);
      else n_pass++;
    end
  endtask

  // Requester inputs change after the grant; the RAM must only ever see the
  // latched command, and a req dropped during WAIT still completes.
  task automatic test_latch_hold(input int d);
    logic [ADDR_W-1:0] a_ok, a_bad;
    logic [DATA_W-1:0] w_ok;
    bit got;
    a_ok  = 9'h0AA;
    a_bad = 9'h155;
    w_ok  = 32'h12345670 + d;
    run_txn(d, 1'b0, 1'b1, a_bad, 32'h0BADF00D, "decoy_wr");
    drive(d, 1'b0, 1'b1, 1'b1, a_ok, w_ok);
    @(negedge clk);
    drive(d, 1'b0, 1'b1, 1'b1, a_bad, 32'hFFFF0000);
    n_checks++;
    if ({ram_wren[d], ram_address[d], ram_data[d]} !== {1'b1, a_ok, w_ok})
      $display("[TB] FAIL hold_issue dut%0d: got wren %b addr %0h data %0h expected 1 %0h %0h",
               d, ram_wren[d], ram_address[d], ram_data[d], a_ok, w_ok);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({cpu_ack[d], ram_wren[d], ram_address[d], ram_data[d]} !== {1'b1, 1'b0, a_ok, w_ok})
      $display("[TB] FAIL hold_ack dut%0d: got ack %b wren %b addr %0h data %0h expected 1 0 %0h %0h",
               d, cpu_ack[d], ram_wren[d], ram_address[d], ram_data[d], a_ok, w_ok);
    else n_pass++;
    cpu_req[d] = 1'b0;
    @(negedge clk);
    note_write(d, a_ok, w_ok);
    drive(d, 1'b0, 1'b1, 1'b0, a_ok, 32'h0);
    @(negedge clk);
    cpu_addr[d] = a_bad;
    n_checks++;
    if ({ram_rden[d], ram_address[d]} !== {1'b1, a_ok})
      $display("[TB] FAIL hold_rd_issue dut%0d: got rden %b addr %0h expected 1 %0h",
               d, ram_rden[d], ram_address[d], a_ok);
    else n_pass++;
    @(negedge clk);
    cpu_req[d] = 1'b0;
    got = 1'b0;
    for (int k = 3; k <= 2 + model_lat(d) + 3 && !got; k++) begin
      @(negedge clk);
      if (cpu_ack[d] === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (k != 2 + model_lat(d) || cpu_rdata[d] !== w_ok)
          $display("[TB] FAIL hold_dropped_ack dut%0d: got k=%0d rdata %0h expected k=%0d rdata %0h",
                   d, k, cpu_rdata[d], 2 + model_lat(d), w_ok);
        else n_pass++;
      end
    end
    if (!got) begin
      n_checks++;
      $display("[TB] FAIL hold_dropped_timeout dut%0d: got no ack expected ack", d);
    end
    @(negedge clk);
    run_txn(d, 1'b0, 1'b0, a_bad, 32'h0, "decoy_rd");
  endtask

  task automatic test_random(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      bit who, we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] w;
      who = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      if (wr_cnt[d] == 0) we = 1'b1;
      if (we) a = ADDR_W'($urandom_range(0, 511));
      else    a = wr_list[d][$urandom_range(0, wr_cnt[d] - 1)];
      w = $urandom;
      run_txn(d, who, we, a, w, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(d, 1'b1, 1'b0, 1'b0, '0, '0);
      wr_cnt[d] = 0;
    end
    $display("[TB] start");
    test_reset();
    for (int d = 0; d < NDUT; d++) test_write_read(d);
    for (int d = 0; d < NDUT; d++) test_contention(d);
    for (int d = 0; d < NDUT; d++) test_reset_mid_read(d);
    for (int d = 0; d < NDUT; d++) test_latch_hold(d);
    for (int d = 0; d < NDUT; d++) test_random(d, 30);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
